// File: rtl/renode_pkg.sv
// Package: renode_pkg
// Shared types for the HDL side of the Renode connection: the message format
// exchanged with renode_connection and the state encoding of the inputs arbiter.
//   message_t   : action + address + data, as carried by send_to_async_receiver
//   action_e    : message kinds (only interrupt is produced by the inputs arbiter)
//   address_t   : line index as seen by Renode (msg_addr is zero-extended to this)
//   data_t      : payload (msg_data occupies bit 0)
//   arb_state_e : renode_inputs_arbiter FSM states
package renode_pkg;

    typedef logic [31:0] address_t;
    typedef logic [63:0] data_t;

    typedef enum logic [7:0] {
        no_action = 8'h00,
        interrupt = 8'h01
    } action_e;

    typedef struct packed {
        action_e  action;
        address_t address;
        data_t    data;
    } message_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_SEND
    } arb_state_e;

    // Builds the interrupt message the wrapper hands to renode_connection.
    function automatic message_t interrupt_message(address_t address, logic level);
        message_t msg;
        msg.action  = interrupt;
        msg.address = address;
        msg.data    = data_t'(level);
        return msg;
    endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Module: renode_rr_arbiter
// Combinational arbiter picking one request out of N.
// Default build: round-robin, the first set request at or after ptr wins
// (wrapping back to index 0). With RENODE_INPUTS_ARB_FIXED_PRIO_EN defined the
// lowest set index always wins and the ptr port does not exist.
// Ports:
//   req       in  N         : request vector
//   ptr       in  IdxWidth  : round-robin start index, must be < N (RR build only)
//   gnt       out N         : one-hot grant (all zero when no request)
//   gnt_idx   out IdxWidth  : encoded index of the granted request
//   gnt_valid out 1         : at least one request is set
module renode_rr_arbiter #(
    parameter int N        = 1,
    parameter int IdxWidth = $clog2((N > 2) ? N : 2)
) (
    input  logic [N-1:0]        req,
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
    input  logic [IdxWidth-1:0] ptr,
`endif
    output logic [N-1:0]        gnt,
    output logic [IdxWidth-1:0] gnt_idx,
    output logic                gnt_valid
);

    int best_k;
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
    int best_off;
    int off;
`endif

    // The winner is the request with the smallest rotated distance from ptr
    // (RR) or simply the lowest index (fixed priority).
    always_comb begin
        best_k = 0;
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
        best_off = N;
        off      = 0;
        for (int k = 0; k < N; k++) begin
            off = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + N - int'(ptr));
            if (req[k] && (off < best_off)) begin
                best_off = off;
                best_k   = k;
            end
        end
`else
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                best_k = k;
            end
        end
`endif
        gnt_valid = |req;
        gnt_idx   = IdxWidth'(best_k);
        gnt       = '0;
        for (int k = 0; k < N; k++) begin
            gnt[k] = gnt_valid && (best_k == k);
        end
    end

endmodule

// File: rtl/renode_inputs_arbiter.sv
// Module: renode_inputs_arbiter
// Tracks InputsCount GPIO/IRQ lines together with the level last reported to
// Renode and serializes every level change into a single interrupt message on a
// valid/ready port. Lines are served round-robin so a busy line cannot starve
// the others; define RENODE_INPUTS_ARB_FIXED_PRIO_EN for lowest-index-first.
// Ports:
//   clk       in  1           : clock, all state on posedge
//   rst       in  1           : asynchronous active-high reset
//   inputs    in  InputsCount : line levels, already synchronous to clk
//   msg_valid out 1           : message offered
//   msg_ready in  1           : consumer accepts (transfer = valid && ready)
//   msg_addr  out AddrWidth   : index of the reported line
//   msg_data  out 1           : level being reported
//   pending   out InputsCount : lines whose level differs from the last report
module renode_inputs_arbiter
    import renode_pkg::*;
#(
    parameter int InputsCount = 1,
    parameter int AddrWidth   = $clog2((InputsCount > 2) ? InputsCount : 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [InputsCount-1:0] inputs,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [AddrWidth-1:0]   msg_addr,
    output logic                   msg_data,
    output logic [InputsCount-1:0] pending
);

    arb_state_e             state;
    logic [InputsCount-1:0] level_sent;
    logic [InputsCount-1:0] gnt;
    logic [AddrWidth-1:0]   gnt_idx;
    logic                   gnt_valid;

    // A line needs reporting whenever its live level differs from what Renode
    // last heard; a pulse that returns before being granted simply vanishes.
    assign pending = inputs ^ level_sent;

`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
    logic [AddrWidth-1:0] rr_ptr;

    renode_rr_arbiter #(.N(InputsCount), .IdxWidth(AddrWidth)) u_arb (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );
`else
    renode_rr_arbiter #(.N(InputsCount), .IdxWidth(AddrWidth)) u_arb (
        .req       (pending),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );
`endif

    // IDLE latches the granted line and its current level into the output
    // registers; SEND holds them until the consumer takes the message. The
    // latched level is what gets recorded as sent, so a change during SEND
    // re-pends the line and its final level is reported next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            level_sent <= '0;
            msg_valid  <= 1'b0;
            msg_addr   <= '0;
            msg_data   <= 1'b0;
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (gnt_valid) begin
                        msg_addr  <= gnt_idx;
                        msg_data  <= |(inputs & gnt);
                        msg_valid <= 1'b1;
                        state     <= ARB_SEND;
                    end
                end
                ARB_SEND: begin
                    if (msg_ready) begin
                        for (int i = 0; i < InputsCount; i++) begin
                            if (msg_addr == AddrWidth'(i)) begin
                                level_sent[i] <= msg_data;
                            end
                        end
                        msg_valid <= 1'b0;
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
                        rr_ptr    <= (msg_addr == AddrWidth'(InputsCount - 1)) ?
                                     '0 : (msg_addr + 1'b1);
`endif
                        state     <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_renode_inputs_arbiter.sv
// Testbench for renode_inputs_arbiter with four lines. Expected messages are
// queued as stimulus is applied and popped by a monitor on every transfer.
module tb_renode_inputs_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] inputs;
    logic       msg_valid;
    logic       msg_ready;
    logic [1:0] msg_addr;
    logic       msg_data;
    logic [3:0] pending;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    logic [2:0] exp_q[$];
    int         xfer_cycles[$];

    renode_inputs_arbiter #(.InputsCount(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .inputs    (inputs),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_addr  (msg_addr),
        .msg_data  (msg_data),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of stimulus just after a rising edge.
    task automatic applyStimulus(input logic [3:0] in_val, input logic rdy);
        @(posedge clk);
        #1;
        inputs    = in_val;
        msg_ready = rdy;
    endtask

    task automatic pushExp(input logic [1:0] addr, input logic data);
        exp_q.push_back({addr, data});
    endtask

    task automatic waitValid(input string tag);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (msg_valid) break;
        end
        checkOutput(tag, 32'(msg_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && msg_valid && msg_ready) begin
            xfer_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_msg", {29'd0, msg_addr, msg_data}, 32'hFFFF_FFFF);
            end else begin
                checkOutput("msg", {29'd0, msg_addr, msg_data}, {29'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        inputs    = 4'b0000;
        msg_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(msg_valid), 32'd0);
        checkOutput("rst_addr", 32'(msg_addr), 32'd0);
        checkOutput("rst_data", 32'(msg_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with all lines low
        msg_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_valid", 32'(msg_valid), 32'd0);
            checkOutput("idle_pending", 32'(pending), 32'd0);
        end

        // Two simultaneous rises: line 0 then line 2, two cycles apart
        $display("[TB] two-line change");
        xfer_cycles.delete();
        pushExp(2'd0, 1'b1);
        pushExp(2'd2, 1'b1);
        applyStimulus(4'b0101, 1'b1);
        drain("pair_drain");
        checkOutput("pair_count", 32'(xfer_cycles.size()), 32'd2);
        if (xfer_cycles.size() == 2)
            checkOutput("pair_gap", 32'(xfer_cycles[1] - xfer_cycles[0]), 32'd2);
        checkOutput("pair_pending", 32'(pending), 32'd0);

        // Stall: line 3 offered and held while the consumer is not ready
        $display("[TB] stall");
        pushExp(2'd3, 1'b1);
        applyStimulus(4'b1101, 1'b0);
        waitValid("stall_valid_seen");
        for (int i = 0; i < 10; i++) begin
            checkOutput("stall_out", {28'd0, msg_valid, msg_addr, msg_data}, {28'd0, 1'b1, 2'd3, 1'b1});
            checkOutput("stall_pend3", 32'(pending[3]), 32'd1);
            @(posedge clk);
            #1;
        end
        msg_ready = 1'b1;
        drain("stall_drain");
        checkOutput("stall_pending", 32'(pending), 32'd0);

        // Coalesce: line 1 pulses while line 0's message is stalled
        $display("[TB] coalesce");
        pushExp(2'd0, 1'b0);
        applyStimulus(4'b1100, 1'b0);
        waitValid("coal_valid_seen");
        applyStimulus(4'b1110, 1'b0);
        applyStimulus(4'b1100, 1'b0);
        applyStimulus(4'b1100, 1'b1);
        drain("coal_drain");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("coal_pending", 32'(pending), 32'd0);
        checkOutput("coal_valid", 32'(msg_valid), 32'd0);

        // Stale: line 2 granted at 1 and dropped before acceptance
        $display("[TB] stale send");
        pushExp(2'd2, 1'b0);
        applyStimulus(4'b1000, 1'b1);
        drain("stale_prep");
        pushExp(2'd2, 1'b1);
        pushExp(2'd2, 1'b0);
        applyStimulus(4'b1100, 1'b0);
        waitValid("stale_valid_seen");
        checkOutput("stale_latched", {30'd0, msg_addr, msg_data} , {29'd0, 2'd2, 1'b1});
        applyStimulus(4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b1);
        drain("stale_drain");
        checkOutput("stale_pending", 32'(pending), 32'd0);

        // Fairness: bring the pointer to 0, then toggle all lines together
        $display("[TB] fairness");
        pushExp(2'd3, 1'b0);
        applyStimulus(4'b0000, 1'b1);
        drain("fair_prep");
        for (int r = 0; r < 4; r++) begin
            logic lvl;
            lvl = (r % 2 == 0);
            for (int l = 0; l < 4; l++) pushExp(2'(l), lvl);
            applyStimulus(lvl ? 4'b1111 : 4'b0000, 1'b1);
            drain("fair_round");
        end
        // Line 0 re-pends during its own send while line 2 rises
        pushExp(2'd0, 1'b1);
`ifndef RENODE_INPUTS_ARB_FIXED_PRIO_EN
        pushExp(2'd2, 1'b1);
        pushExp(2'd0, 1'b0);
`else
        pushExp(2'd0, 1'b0);
        pushExp(2'd2, 1'b1);
`endif
        applyStimulus(4'b0001, 1'b0);
        waitValid("fair_valid_seen");
        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b1);
        drain("fair_order");

        // Asynchronous reset while a message is offered
        $display("[TB] reset mid-send");
        applyStimulus(4'b0010, 1'b0);
        waitValid("rst_send_valid_seen");
        checkOutput("rst_send_addr", 32'(msg_addr), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 32'(msg_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pushExp(2'd1, 1'b1);
        msg_ready = 1'b1;
        drain("rst_resend");
        checkOutput("rst_final_pending", 32'(pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
